// File: rtl/sigmoid_lut_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : sigmoid_lut_arbiter                                               |
// | Purpose : round-robin sharing of one sigmoid ROM among NUM_REQ requesters    |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module sigmoid_lut_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [16*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [6:0]            rom_addr,
   input  logic [15:0]           rom_data,
   output logic                  out_valid,
   output logic [7:0]            out_data,
   output logic [ID_W-1:0]       out_id,
   input  logic                  out_ready,
   output logic                  busy
);

   localparam logic [6:0]  C_K_MAX    = 7'd60;
   localparam logic [11:0] C_K_MAX_12 = 12'd60;

   logic               w_stall;
   logic               w_any;
   logic               w_take;
   logic [NUM_REQ-1:0] w_gnt;
   logic [ID_W-1:0]    w_gidx;
   logic [15:0]        w_x;
   logic [15:0]        w_negx;
   logic [14:0]        w_abs;
   logic [19:0]        w_p;
   logic [19:0]        w_psum;
   logic [11:0]        w_k12;
   logic [6:0]         w_k;
   logic [7:0]         w_d;
   logic [8:0]         w_inv;
   logic [7:0]         w_res;
   logic               w_unused;

   logic [ID_W-1:0]    r_ptr;
   logic               r_s;
   logic [ID_W-1:0]    r_id1;
   logic               r_v1;

   assign w_stall = out_valid & ~out_ready;

   // Scan requesters starting at the pointer; first valid one wins.
   always_comb begin : p_arb
      int idx;
      w_gnt  = '0;
      w_gidx = '0;
      w_any  = 1'b0;
      w_x    = '0;
      idx    = 0;
      for (int j = 0; j < NUM_REQ; j++) begin
         idx = int'(r_ptr) + j;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!w_any && req_valid[idx]) begin
            w_any      = 1'b1;
            w_gidx     = ID_W'(idx);
            w_gnt[idx] = 1'b1;
            w_x        = req_data[16*idx +: 16];
         end
      end
   end

   assign w_take    = w_any & ~w_stall;
   assign req_ready = (rst | w_stall) ? '0 : w_gnt;

   // |x| with the most negative value pinned to +32767
   assign w_negx = 16'd0 - w_x;
   always_comb begin
      w_abs = w_x[14:0];
      if (w_x[15]) w_abs = (w_x == 16'h8000) ? 15'h7fff : w_negx[14:0];
   end

   assign w_p    = {5'd0, w_abs} * 20'd10;
   assign w_psum = w_p + 20'd128;
   assign w_k12  = w_psum[19:8];
   assign w_k    = (w_k12 > C_K_MAX_12) ? C_K_MAX : w_k12[6:0];

   assign w_d   = rom_data[7:0];
   assign w_inv = 9'd256 - {1'b0, w_d};
   assign w_res = r_s ? w_inv[7:0] : w_d;

   assign w_unused = ^{rom_data[15:8], w_psum[7:0], w_inv[8], w_negx[15]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr     <= '0;
         rom_addr  <= '0;
         r_s       <= 1'b0;
         r_id1     <= '0;
         r_v1      <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_id    <= '0;
      end else if (!w_stall) begin
         if (w_take) begin
            r_ptr    <= (w_gidx == ID_W'(NUM_REQ-1)) ? '0 : w_gidx + ID_W'(1);
            rom_addr <= w_k;
            r_s      <= w_x[15];
            r_id1    <= w_gidx;
            r_v1     <= 1'b1;
         end else begin
            r_v1     <= 1'b0;
         end
         out_valid <= r_v1;
         out_data  <= w_res;
         out_id    <= r_id1;
      end
   end

   assign busy = r_v1 | out_valid;

endmodule
`default_nettype wire
